// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, parity encodings and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width of a counter that must hold the values 0..n.
  function automatic int bit_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period divider: tick is high on the last clk of every CLKS_PER_BIT-cycle bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte at a time and serialises each byte as a UART frame on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = bit_cnt_w(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  tick, clear, done;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:  if (enable && !fifo_empty) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = fifo_data;
        par_d   = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
        state_d = ST_START;
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP: begin
        if (tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = (enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state entry restarts both the bit period and the bit index.
    clear = (state_d != state_q);
    if (clear) bit_d = '0;

    // tx follows the state being entered so the line changes on the same edge as the FSM.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = (state_q == ST_FETCH);
  assign fifo_cs    = (state_q == ST_FETCH);
  assign busy       = (state_q != ST_IDLE);
  assign tx_done    = done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitters (no parity/1 stop, even/1 stop, odd/2 stop) each fed by a queue-based FIFO
// model; a per-line sampler checks every cycle of each frame against a scoreboard of queued bytes.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int NI = 3;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] en    = '0;
  logic [NI-1:0] empty = '1;
  logic [NI-1:0] tx, busy, rd_en, cs, done;
  logic [7:0]    fdata [NI];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic [7:0] fq [NI][$];
  exp_t       sb [NI][$];
  int         gaps [NI][$];
  int         rd_cnt   [NI] = '{default: 0};
  int         frames   [NI] = '{default: 0};
  int         starts   [NI] = '{default: 0};
  int         done_cnt [NI] = '{default: 0};
  int         last_end [NI] = '{default: -1};

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(fdata[0]),
    .fifo_cs(cs[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(fdata[1]),
    .fifo_cs(cs[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(fdata[2]),
    .fifo_cs(cs[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic p);
    fq[k].push_back(d);
    sb[k].push_back('{d, p});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a pop returns data before the DUT's LOAD edge, as a registered data_out would.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rd_en[k]) begin
        check("cs_with_rd_en", cs[k], 1);
        check("rd_en_while_nonempty", fq[k].size() > 0, 1);
        check("no_tx_done_with_rd_en", done[k], 0);
        if (fq[k].size() > 0) fdata[k] = fq[k].pop_front();
        rd_cnt[k]++;
      end
      if (done[k]) done_cnt[k]++;
      empty[k] = (fq[k].size() == 0);
    end
  end

  task automatic run_frame(input int k);
    exp_t       e;
    logic [11:0] bits;
    int         nb;
    bit         ok, abort;
    logic       got_tx, got_busy, got_done;
    starts[k]++;
    if (last_end[k] >= 0) gaps[k].push_back(cyc - last_end[k] - 1);
    if (sb[k].size() == 0) begin
      check("unexpected_frame", 0, 1);
      e = '{8'h00, 1'b0};
    end else begin
      e = sb[k].pop_front();
    end
    bits = '0;
    nb   = 1;
    for (int i = 0; i < 8; i++) begin bits[nb] = e.d[i]; nb++; end
    if (k != 0) begin bits[nb] = e.p; nb++; end
    for (int s = 0; s < ((k == 2) ? 2 : 1); s++) begin bits[nb] = 1'b1; nb++; end
    abort = 1'b0;
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      got_tx = 1'b0; got_busy = 1'b0; got_done = 1'b0;
      for (int c = 0; c < C; c++) begin
        if (!abort) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst) abort = 1'b1;
          else if (tx[k] !== bits[b] || busy[k] !== 1'b1 ||
                   done[k] !== ((b == nb - 1) && (c == C - 1))) begin
            if (ok) begin got_tx = tx[k]; got_busy = busy[k]; got_done = done[k]; end
            ok = 1'b0;
          end
        end
      end
      if (!abort) begin
        n_chk++;
        if (!ok) begin
          n_fail++;
          $display("FAIL frame_bit line%0d byte %h bit %0d: got tx=%b busy=%b tx_done=%b, expected tx=%b busy=1 tx_done=%b",
                   k, e.d, b, got_tx, got_busy, got_done, bits[b], (b == nb - 1));
        end
      end
    end
    if (!abort) begin
      frames[k]++;
      last_end[k] = cyc;
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    initial begin
      forever begin
        @(negedge clk);
        if (!rst && tx[g] === 1'b0) run_frame(g);
      end
    end
  end

  task automatic wait_frames(input int k, input int n, input int budget);
    int t = 0;
    while (frames[k] < n && t < budget) begin @(posedge clk); t++; end
    check("frames_received", frames[k], n);
  endtask

  task automatic wait_start(input int k, input int n, input int budget);
    int t = 0;
    while (starts[k] < n && t < budget) begin @(negedge clk); t++; end
    check("frame_started", starts[k], n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int rd0, fr0, dc0, st0;
    int dc1, dc2;
    logic [7:0] drain_b;

    // Reset held for three cycles, then idle with enable high and empty FIFOs.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("reset_tx", tx[k], 1);
      check("reset_busy", busy[k], 0);
      check("reset_rd_en", rd_en[k], 0);
    end
    rst = 1'b0;
    en  = '1;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("idle_empty_tx", tx[k], 1);
      check("idle_empty_busy", busy[k], 0);
      check("idle_empty_no_reads", rd_cnt[k], 0);
    end

    // Single byte 8'hA5: line must read 0,1,0,1,0,0,1,0,1,1.
    rd0 = rd_cnt[0]; fr0 = frames[0]; dc0 = done_cnt[0];
    push(0, 8'hA5, 1'b0);
    wait_frames(0, fr0 + 1, 200);
    repeat (5) @(posedge clk);
    #1;
    check("single_rd_pulses", rd_cnt[0] - rd0, 1);
    check("single_tx_done_pulses", done_cnt[0] - dc0, 1);
    check("single_fifo_empty", empty[0], 1);
    check("single_idle_busy", busy[0], 0);

    // Drain eight queued bytes back to back.
    en[0] = 1'b0;
    @(posedge clk);
    rd0 = rd_cnt[0]; fr0 = frames[0];
    for (int i = 1; i <= 8; i++) begin
      drain_b = 8'(i);
      push(0, drain_b, 1'b0);
    end
    gaps[0].delete();
    repeat (3) @(posedge clk);
    en[0] = 1'b1;
    wait_frames(0, fr0 + 8, 1000);
    repeat (5) @(posedge clk);
    #1;
    check("drain_rd_pulses", rd_cnt[0] - rd0, 8);
    check("drain_gap_count", gaps[0].size(), 8);
    for (int i = 1; i < gaps[0].size(); i++) check("drain_gap_cycles", gaps[0][i], 2);
    check("drain_fifo_empty", empty[0], 1);

    // Parity: 8'h07 -> even parity bit 1, odd parity bit 0; odd line also has two stop bits.
    dc1 = done_cnt[1]; dc2 = done_cnt[2];
    push(1, 8'h07, 1'b1);
    push(2, 8'h07, 1'b0);
    wait_frames(1, 1, 200);
    wait_frames(2, 1, 200);
    repeat (5) @(posedge clk);
    check("even_tx_done_pulses", done_cnt[1] - dc1, 1);
    check("odd_tx_done_pulses", done_cnt[2] - dc2, 1);
    check("odd_rd_pulses", rd_cnt[2], 1);

    // Enable dropped mid-DATA of the first of three bytes.
    en[0] = 1'b0;
    @(posedge clk);
    rd0 = rd_cnt[0]; fr0 = frames[0]; st0 = starts[0];
    push(0, 8'h3C, 1'b0);
    push(0, 8'hC3, 1'b0);
    push(0, 8'h5A, 1'b0);
    @(posedge clk);
    en[0] = 1'b1;
    wait_start(0, st0 + 1, 50);
    repeat (12) @(posedge clk);
    en[0] = 1'b0;
    wait_frames(0, fr0 + 1, 200);
    repeat (40) @(posedge clk);
    #1;
    check("en_drop_rd_pulses", rd_cnt[0] - rd0, 1);
    check("en_drop_fifo_left", fq[0].size(), 2);
    check("en_drop_frames", frames[0] - fr0, 1);
    check("en_drop_idle_busy", busy[0], 0);
    en[0] = 1'b1;
    wait_frames(0, fr0 + 3, 300);
    repeat (5) @(posedge clk);
    #1;
    check("en_return_rd_pulses", rd_cnt[0] - rd0, 3);
    check("en_return_fifo_empty", empty[0], 1);

    // Reset during DATA bit 3; the popped byte is lost, the next one must go out intact.
    en[0] = 1'b0;
    @(posedge clk);
    rd0 = rd_cnt[0]; fr0 = frames[0]; st0 = starts[0];
    push(0, 8'h96, 1'b0);
    push(0, 8'h69, 1'b0);
    @(posedge clk);
    en[0] = 1'b1;
    wait_start(0, st0 + 1, 50);
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_tx", tx[0], 1);
    check("midreset_busy", busy[0], 0);
    check("midreset_rd_en", rd_en[0], 0);
    #1 rst = 1'b0;
    check("midreset_frame_abandoned", frames[0] - fr0, 0);
    wait_frames(0, fr0 + 1, 200);
    repeat (5) @(posedge clk);
    #1;
    check("midreset_rd_pulses", rd_cnt[0] - rd0, 2);
    check("midreset_fifo_empty", empty[0], 1);
    check("scoreboard_drained", sb[0].size() + sb[1].size() + sb[2].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
